// File: rtl/reg_serializer_pkg.sv
// Shared types and sizing helpers for the register serializer.
package reg_serializer_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int unsigned DEFAULT_WIDTH = 32;

    // Counter width able to hold the values 0..width inclusive.
    function automatic int unsigned cnt_w(input int unsigned width);
        return 32'($clog2(width + 1));
    endfunction

    localparam int unsigned CNT_W = cnt_w(DEFAULT_WIDTH);

endpackage

// File: rtl/piso_shift.sv
// Parallel-in serial-out shift register; the serial bit is a direct register tap.
module piso_shift #(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_en,
    input  logic             shift_en,
    input  logic             fill,
    input  logic [WIDTH-1:0] d,
    output logic             sout
);

    logic [WIDTH-1:0] sr;

    generate
        if (MSB_FIRST) begin : g_msb
            always_ff @(posedge clk) begin
                if (reset) begin
                    sr <= '0;
                end else if (load_en) begin
                    sr <= d;
                end else if (shift_en) begin
                    sr <= {sr[WIDTH-2:0], fill};
                end
            end
            assign sout = sr[WIDTH-1];
        end else begin : g_lsb
            always_ff @(posedge clk) begin
                if (reset) begin
                    sr <= '0;
                end else if (load_en) begin
                    sr <= d;
                end else if (shift_en) begin
                    sr <= {fill, sr[WIDTH-1:1]};
                end
            end
            assign sout = sr[0];
        end
    endgenerate

endmodule

// File: rtl/reg_serializer.sv
// Drains a captured word one bit per valid/ready transfer; FSM, bit counter and done pulse.
module reg_serializer
    import reg_serializer_pkg::*;
#(
    parameter int unsigned WIDTH     = 32,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [WIDTH-1:0]          d,
    input  logic                      load,
    input  logic                      ready,
    output logic                      sout,
    output logic                      valid,
    output logic                      busy,
    output logic [cnt_w(WIDTH)-1:0]   remaining,
    output logic                      done
);

    localparam int unsigned CW = cnt_w(WIDTH);

    state_t state;
    logic   load_en;
    logic   shift_en;

    // A load is only taken from IDLE; a shift only when the consumer takes the bit.
    assign load_en  = (state == IDLE) && load;
    assign shift_en = (state == SHIFT) && ready;

    piso_shift #(
        .WIDTH     (WIDTH),
        .MSB_FIRST (MSB_FIRST)
    ) u_piso (
        .clk      (clk),
        .reset    (reset),
        .load_en  (load_en),
        .shift_en (shift_en),
        .fill     (1'b0),
        .d        (d),
        .sout     (sout)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            valid     <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            remaining <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (load) begin
                        state     <= SHIFT;
                        valid     <= 1'b1;
                        busy      <= 1'b1;
                        remaining <= CW'(WIDTH);
                    end
                end
                SHIFT: begin
                    if (ready) begin
                        remaining <= remaining - CW'(1);
                        // Last bit accepted: back to IDLE with a one-cycle done.
                        if (remaining == CW'(1)) begin
                            state <= IDLE;
                            valid <= 1'b0;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    valid <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_reg_serializer.sv
// Bench for reg_serializer: 32-bit MSB-first and 8-bit LSB-first instances against a pending-bit model.
module tb_reg_serializer;

    logic        clk = 1'b0;
    logic        reset;
    logic        load;
    logic        ready;
    logic [31:0] d;

    logic       sout32, valid32, busy32, done32;
    logic [5:0] rem32;
    logic       sout8, valid8, busy8, done8;
    logic [3:0] rem8;

    int checks = 0;
    int errors = 0;

    // Model: pending bits listed so that the next bit out is pend[cnt-1].
    logic [31:0] pend [2];
    int          cnt  [2];
    bit          dn   [2];
    int          wd   [2];
    bit          msb  [2];

    logic [31:0] w;
    logic [7:0]  w8;
    logic [31:0] word;

    always #5 clk = ~clk;

    reg_serializer #(.WIDTH(32), .MSB_FIRST(1'b1)) dut32 (
        .clk(clk), .reset(reset), .d(d), .load(load), .ready(ready),
        .sout(sout32), .valid(valid32), .busy(busy32), .remaining(rem32), .done(done32)
    );

    reg_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) dut8 (
        .clk(clk), .reset(reset), .d(d[7:0]), .load(load), .ready(ready),
        .sout(sout8), .valid(valid8), .busy(busy8), .remaining(rem8), .done(done8)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic model_edge(input logic rst, input logic ld, input logic rdy, input logic [31:0] dv);
        for (int i = 0; i < 2; i++) begin
            if (rst) begin
                cnt[i]  = 0;
                dn[i]   = 1'b0;
                pend[i] = '0;
            end else begin
                dn[i] = (cnt[i] == 1) && rdy;
                if (cnt[i] > 0) begin
                    if (rdy) cnt[i]--;
                end else if (ld) begin
                    pend[i] = '0;
                    for (int b = 0; b < wd[i]; b++)
                        pend[i][b] = msb[i] ? dv[b] : dv[wd[i]-1-b];
                    cnt[i] = wd[i];
                end
            end
        end
    endtask

    task automatic check_model();
        logic exp_sout;
        for (int i = 0; i < 2; i++) begin
            exp_sout = (cnt[i] > 0) ? pend[i][cnt[i]-1] : 1'b0;
            chk($sformatf("sout_w%0d", wd[i]),      32'(i == 0 ? sout32  : sout8),  32'(exp_sout));
            chk($sformatf("valid_w%0d", wd[i]),     32'(i == 0 ? valid32 : valid8), 32'(cnt[i] > 0));
            chk($sformatf("busy_w%0d", wd[i]),      32'(i == 0 ? busy32  : busy8),  32'(cnt[i] > 0));
            chk($sformatf("remaining_w%0d", wd[i]), i == 0 ? 32'(rem32) : 32'(rem8), 32'(cnt[i]));
            chk($sformatf("done_w%0d", wd[i]),      32'(i == 0 ? done32  : done8),  32'(dn[i]));
        end
    endtask

    // Drive inputs for one cycle, take the edge, then sample 1 time unit later.
    task automatic step(input logic rst, input logic ld, input logic rdy, input logic [31:0] dv);
        reset = rst;
        load  = ld;
        ready = rdy;
        d     = dv;
        @(posedge clk);
        model_edge(rst, ld, rdy, dv);
        #1;
        check_model();
    endtask

    task automatic drain();
        for (int n = 0; n < 100 && (cnt[0] != 0 || cnt[1] != 0); n++)
            step(1'b0, 1'b0, 1'b1, 32'h0);
        step(1'b0, 1'b0, 1'b1, 32'h0);
    endtask

    initial begin
        wd[0] = 32; msb[0] = 1'b1;
        wd[1] = 8;  msb[1] = 1'b0;
        for (int i = 0; i < 2; i++) begin
            cnt[i] = 0; dn[i] = 1'b0; pend[i] = '0;
        end
        reset = 1'b1; load = 1'b0; ready = 1'b0; d = '0;

        // Reset then idle
        step(1'b1, 1'b0, 1'b0, 32'h0);
        step(1'b1, 1'b0, 1'b0, 32'h0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b0, 1'($urandom_range(0, 1)), $urandom());
            chk("idle_valid", 32'(valid32), 32'h0);
            chk("idle_sout",  32'(sout32),  32'h0);
            chk("idle_rem",   32'(rem32),   32'h0);
        end

        // Full word MSB first, ready always high
        step(1'b0, 1'b1, 1'b1, 32'hA5A5_0001);
        w = '0;
        for (int i = 0; i < 32; i++) begin
            w = {w[30:0], sout32};
            chk("full_rem", 32'(rem32), 32'(32 - i));
            chk("full_done_early", 32'(done32), 32'h0);
            step(1'b0, 1'b0, 1'b1, 32'h0);
        end
        chk("full_word", w, 32'hA5A5_0001);
        chk("full_done", 32'(done32), 32'h1);
        chk("full_rem_end", 32'(rem32), 32'h0);
        drain();

        // Backpressure: ready low for 10 cycles after the load
        step(1'b0, 1'b1, 1'b0, 32'h8000_0000);
        for (int i = 0; i < 10; i++) begin
            chk("bp_sout", 32'(sout32), 32'h1);
            chk("bp_rem",  32'(rem32),  32'd32);
            step(1'b0, 1'b0, 1'b0, 32'h0);
        end
        w = '0;
        for (int i = 0; i < 32; i++) begin
            w = {w[30:0], sout32};
            step(1'b0, 1'b0, 1'b1, 32'h0);
        end
        chk("bp_word", w, 32'h8000_0000);
        chk("bp_done", 32'(done32), 32'h1);
        drain();

        // Load while busy is ignored; load in the done cycle is taken
        word = $urandom();
        step(1'b0, 1'b1, 1'b1, word);
        w = '0;
        for (int i = 0; i < 32; i++) begin
            w = {w[30:0], sout32};
            chk("lwb_rem", 32'(rem32), 32'(32 - i));
            step(1'b0, 1'(i == 12), 1'b1, (i == 12) ? 32'hFFFF_FFFF : 32'h0);
        end
        chk("lwb_word", w, word);
        chk("lwb_done", 32'(done32), 32'h1);
        step(1'b0, 1'b1, 1'b1, $urandom());
        chk("lwb_reload_rem", 32'(rem32), 32'd32);
        drain();

        // Reset mid-word, then reset+load together, then a fresh word
        step(1'b0, 1'b1, 1'b1, $urandom());
        for (int i = 0; i < 27; i++) step(1'b0, 1'b0, 1'b1, 32'h0);
        chk("rmw_rem5", 32'(rem32), 32'd5);
        step(1'b1, 1'b0, 1'b1, 32'h0);
        chk("rmw_valid", 32'(valid32), 32'h0);
        chk("rmw_busy",  32'(busy32),  32'h0);
        chk("rmw_rem",   32'(rem32),   32'h0);
        for (int i = 0; i < 6; i++) begin
            step(1'b0, 1'b0, 1'b1, 32'h0);
            chk("rmw_no_done", 32'(done32), 32'h0);
        end
        step(1'b1, 1'b1, 1'b1, 32'hFFFF_FFFF);
        chk("rst_load_valid", 32'(valid32), 32'h0);
        step(1'b0, 1'b1, 1'b1, 32'h0000_0003);
        w = '0;
        for (int i = 0; i < 32; i++) begin
            w = {w[30:0], sout32};
            step(1'b0, 1'b0, 1'b1, 32'h0);
        end
        chk("rmw_fresh_word", w, 32'h0000_0003);
        drain();

        // LSB first on the 8-bit instance
        step(1'b0, 1'b1, 1'b1, 32'h0000_0006);
        w8 = '0;
        for (int i = 0; i < 8; i++) begin
            w8[i] = sout8;
            chk("lsb_done_early", 32'(done8), 32'h0);
            step(1'b0, 1'b0, 1'b1, 32'h0);
        end
        chk("lsb_seq", 32'(w8), 32'h0000_0006);
        chk("lsb_done", 32'(done8), 32'h1);
        drain();

        // Randomized traffic against the model
        for (int i = 0; i < 600; i++)
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 9) < 3),
                 1'($urandom_range(0, 9) < 6), $urandom());

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
